// File: rtl/rv32_alu_issue_if.sv
// Bus bundle between the ALU issue sequencer, decode, the ALU FSM and writeback.
// Signal names are seen from the sequencer: i_* flows into it, o_* flows out of it.
interface rv32_alu_issue_if;
  // decode side
  logic        i_dec_valid;
  logic        o_dec_ready;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] i_imm;
  logic        i_use_imm;
  logic [1:0]  i_alu_sel;
  logic [4:0]  i_rd_addr;
  // ALU side
  logic        o_en_alu;
  logic        o_alu_rst;
  logic [31:0] o_operand_one;
  logic [31:0] o_operand_two;
  logic [1:0]  o_alu_sel;
  logic        i_alu_data_valid;
  logic [31:0] i_alu_result;
  logic        i_alu_carry;
  // writeback side and status
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_data;
  logic        o_wb_carry;
  logic [4:0]  o_wb_rd_addr;
  logic        o_timeout_err;
  logic        o_busy;

  // The sequencer itself.
  modport slave (
    input  i_dec_valid, i_rs1_data, i_rs2_data, i_imm, i_use_imm, i_alu_sel, i_rd_addr,
    input  i_alu_data_valid, i_alu_result, i_alu_carry, i_wb_ready,
    output o_dec_ready, o_en_alu, o_alu_rst, o_operand_one, o_operand_two, o_alu_sel,
    output o_wb_valid, o_wb_data, o_wb_carry, o_wb_rd_addr, o_timeout_err, o_busy
  );

  // Everything around the sequencer (decode, ALU, writeback).
  modport master (
    output i_dec_valid, i_rs1_data, i_rs2_data, i_imm, i_use_imm, i_alu_sel, i_rd_addr,
    output i_alu_data_valid, i_alu_result, i_alu_carry, i_wb_ready,
    input  o_dec_ready, o_en_alu, o_alu_rst, o_operand_one, o_operand_two, o_alu_sel,
    input  o_wb_valid, o_wb_data, o_wb_carry, o_wb_rd_addr, o_timeout_err, o_busy
  );
endinterface

// File: rtl/rv32_alu_issue.sv
// Issue sequencer in front of rv32_alu_fsm: latches one decoded op, holds the ALU
// operands while waiting (bounded) for its result, hands it to writeback, then resets the ALU.
module rv32_alu_issue #(
  parameter int unsigned TIMEOUT = 5
) (
  input logic              i_clk,
  input logic              i_rst,
  rv32_alu_issue_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_HOLD    = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [1:0]    sel_q, sel_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_carry_q, wb_carry_d;
  logic          err_q, err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      sel_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_data_q  <= '0;
      wb_carry_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_data_q  <= wb_data_d;
      wb_carry_q <= wb_carry_d;
      err_q      <= err_d;
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  // NOTE: every variable gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_data_d  = wb_data_q;
    wb_carry_d = wb_carry_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_dec_valid) begin
          op1_d   = bus.i_rs1_data;
          op2_d   = bus.i_use_imm ? bus.i_imm : bus.i_rs2_data;
          sel_d   = bus.i_alu_sel;
          rd_d    = bus.i_rd_addr;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (bus.i_alu_data_valid) begin
          wb_data_d  = bus.i_alu_result;
          wb_carry_d = bus.i_alu_carry;
          state_d    = (rd_q != 5'd0) ? S_HOLD : S_RECOVER;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_RECOVER;
          end
        end
      end
      S_HOLD: begin
        if (bus.i_wb_ready) state_d = S_RECOVER;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Ready depends only on registered state and reset, never on wb/ALU inputs.
  assign bus.o_dec_ready   = (state_q == S_IDLE) && !i_rst;
  assign bus.o_en_alu      = (state_q == S_ISSUE) || (state_q == S_HOLD);
  assign bus.o_alu_rst     = i_rst || (state_q == S_RECOVER);
  assign bus.o_operand_one = op1_q;
  assign bus.o_operand_two = op2_q;
  assign bus.o_alu_sel     = sel_q;
  assign bus.o_wb_valid    = (state_q == S_HOLD);
  assign bus.o_wb_data     = wb_data_q;
  assign bus.o_wb_carry    = wb_carry_q;
  assign bus.o_wb_rd_addr  = rd_q;
  assign bus.o_timeout_err = err_q;
  assign bus.o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Directed bench for rv32_alu_issue: a table of single operations plus hand-written
// sequences for timeout, reset during ISSUE and back-to-back decode pressure.
module tb_rv32_alu_issue;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rv32_alu_issue_if bus ();

  rv32_alu_issue #(.TIMEOUT(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [1:0]  sel;
    logic [4:0]  rd;
    int          delay;    // invalid ISSUE cycles before the ALU answers
    logic [31:0] res;
    logic        carry;
    logic [31:0] exp_op2;
    int          hold;     // cycles with wb_ready low while in HOLD
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v, input logic exp_err);
    @(negedge clk);
    check("idle_ready", 32'(bus.o_dec_ready), 32'd1);
    check("idle_busy",  32'(bus.o_busy),      32'd0);
    bus.i_rs1_data  = v.rs1;
    bus.i_rs2_data  = v.rs2;
    bus.i_imm       = v.imm;
    bus.i_use_imm   = v.use_imm;
    bus.i_alu_sel   = v.sel;
    bus.i_rd_addr   = v.rd;
    bus.i_dec_valid = 1'b1;
    bus.i_wb_ready  = (v.hold == 0);
    @(negedge clk);
    bus.i_dec_valid = 1'b0;
    bus.i_rs1_data  = ~v.rs1;
    bus.i_rs2_data  = ~v.rs2;
    bus.i_imm       = ~v.imm;
    check("issue_en",    32'(bus.o_en_alu),      32'd1);
    check("issue_op1",   bus.o_operand_one,      v.rs1);
    check("issue_op2",   bus.o_operand_two,      v.exp_op2);
    check("issue_sel",   32'(bus.o_alu_sel),     32'(v.sel));
    check("issue_ready", 32'(bus.o_dec_ready),   32'd0);
    check("issue_busy",  32'(bus.o_busy),        32'd1);
    repeat (v.delay) begin
      check("wait_en",  32'(bus.o_en_alu),   32'd1);
      check("wait_wbv", 32'(bus.o_wb_valid), 32'd0);
      @(negedge clk);
    end
    check("wait_op1", bus.o_operand_one, v.rs1);
    check("wait_op2", bus.o_operand_two, v.exp_op2);
    bus.i_alu_data_valid = 1'b1;
    bus.i_alu_result     = v.res;
    bus.i_alu_carry      = v.carry;
    @(negedge clk);
    bus.i_alu_data_valid = 1'b0;
    bus.i_alu_result     = 32'hBAD0_BAD0;
    bus.i_alu_carry      = ~v.carry;
    if (v.rd != 5'd0) begin
      for (int h = 0; h < v.hold; h++) begin
        check("stall_wbv",  32'(bus.o_wb_valid), 32'd1);
        check("stall_data", bus.o_wb_data,       v.res);
        check("stall_en",   32'(bus.o_en_alu),   32'd1);
        check("stall_op2",  bus.o_operand_two,   v.exp_op2);
        @(negedge clk);
      end
      check("hold_wbv",   32'(bus.o_wb_valid),   32'd1);
      check("hold_data",  bus.o_wb_data,         v.res);
      check("hold_carry", 32'(bus.o_wb_carry),   32'(v.carry));
      check("hold_rd",    32'(bus.o_wb_rd_addr), 32'(v.rd));
      check("hold_en",    32'(bus.o_en_alu),     32'd1);
      check("hold_op1",   bus.o_operand_one,     v.rs1);
      bus.i_wb_ready = 1'b1;
      @(negedge clk);
    end else begin
      check("x0_no_wbv", 32'(bus.o_wb_valid), 32'd0);
    end
    check("rec_alu_rst", 32'(bus.o_alu_rst),   32'd1);
    check("rec_en",      32'(bus.o_en_alu),    32'd0);
    check("rec_wbv",     32'(bus.o_wb_valid),  32'd0);
    check("rec_ready",   32'(bus.o_dec_ready), 32'd0);
    @(negedge clk);
    check("post_alu_rst", 32'(bus.o_alu_rst),     32'd0);
    check("post_ready",   32'(bus.o_dec_ready),   32'd1);
    check("post_err",     32'(bus.o_timeout_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rs1           rs2           imm           imm  sel   rd     dly res           cy    exp_op2       hold
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_DEAD, 1'b0, 2'd0, 5'd7,  2, 32'h0000_0008, 1'b0, 32'h0000_0003, 0};
    vecs[1] = '{32'h0000_0001, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2'd0, 5'd3,  0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 0};
    vecs[2] = '{32'h0000_000A, 32'h0000_0005, 32'h0000_0001, 1'b0, 2'd1, 5'd12, 1, 32'h0000_0005, 1'b0, 32'h0000_0005, 10};
    vecs[3] = '{32'h0000_0007, 32'h0000_0009, 32'h0000_0002, 1'b0, 2'd2, 5'd0,  0, 32'h0000_0001, 1'b0, 32'h0000_0009, 0};
    vecs[4] = '{32'hCAFE_0000, 32'h0000_0077, 32'h8000_0000, 1'b1, 2'd3, 5'd31, 4, 32'h1234_5678, 1'b1, 32'h8000_0000, 0};

    rst                  = 1'b1;
    bus.i_dec_valid      = 1'b0;
    bus.i_rs1_data       = '0;
    bus.i_rs2_data       = '0;
    bus.i_imm            = '0;
    bus.i_use_imm        = 1'b0;
    bus.i_alu_sel        = '0;
    bus.i_rd_addr        = '0;
    bus.i_alu_data_valid = 1'b0;
    bus.i_alu_result     = '0;
    bus.i_alu_carry      = 1'b0;
    bus.i_wb_ready       = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_alu_rst", 32'(bus.o_alu_rst),     32'd1);
    check("rst_ready",   32'(bus.o_dec_ready),   32'd0);
    check("rst_en",      32'(bus.o_en_alu),      32'd0);
    check("rst_busy",    32'(bus.o_busy),        32'd0);
    check("rst_wbv",     32'(bus.o_wb_valid),    32'd0);
    check("rst_err",     32'(bus.o_timeout_err), 32'd0);
    check("rst_op1",     bus.o_operand_one,      32'd0);
    check("rst_wbdata",  bus.o_wb_data,          32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready",   32'(bus.o_dec_ready),   32'd1);
    check("rel_alu_rst", 32'(bus.o_alu_rst),     32'd0);

    // single operations from the table
    foreach (vecs[i]) run_op(vecs[i], 1'b0);

    // timeout: ALU never answers, TIMEOUT=5
    @(negedge clk);
    bus.i_rs1_data  = 32'h0000_0042;
    bus.i_rs2_data  = 32'h0000_0001;
    bus.i_use_imm   = 1'b0;
    bus.i_rd_addr   = 5'd4;
    bus.i_dec_valid = 1'b1;
    @(negedge clk);
    bus.i_dec_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("to_wait_en",  32'(bus.o_en_alu),      32'd1);
      check("to_wait_err", 32'(bus.o_timeout_err), 32'd0);
      @(negedge clk);
    end
    check("to_err",     32'(bus.o_timeout_err), 32'd1);
    check("to_alu_rst", 32'(bus.o_alu_rst),     32'd1);
    check("to_en",      32'(bus.o_en_alu),      32'd0);
    check("to_wbv",     32'(bus.o_wb_valid),    32'd0);
    @(negedge clk);
    check("to_idle_ready", 32'(bus.o_dec_ready),   32'd1);
    check("to_sticky",     32'(bus.o_timeout_err), 32'd1);
    run_op(vecs[0], 1'b1);

    // reset asserted during ISSUE, with a result arriving in the same cycle
    @(negedge clk);
    bus.i_rs1_data  = 32'h0000_0099;
    bus.i_rd_addr   = 5'd9;
    bus.i_dec_valid = 1'b1;
    @(negedge clk);
    bus.i_dec_valid = 1'b0;
    check("mid_en", 32'(bus.o_en_alu), 32'd1);
    rst                  = 1'b1;
    bus.i_alu_data_valid = 1'b1;
    bus.i_alu_result     = 32'h0000_0055;
    #1;
    check("mid_alu_rst", 32'(bus.o_alu_rst),   32'd1);
    check("mid_ready",   32'(bus.o_dec_ready), 32'd0);
    @(negedge clk);
    check("mr_en",      32'(bus.o_en_alu),      32'd0);
    check("mr_busy",    32'(bus.o_busy),        32'd0);
    check("mr_wbv",     32'(bus.o_wb_valid),    32'd0);
    check("mr_err",     32'(bus.o_timeout_err), 32'd0);
    check("mr_op1",     bus.o_operand_one,      32'd0);
    check("mr_wbdata",  bus.o_wb_data,          32'd0);
    check("mr_rd",      32'(bus.o_wb_rd_addr),  32'd0);
    check("mr_alu_rst", 32'(bus.o_alu_rst),     32'd1);
    rst                  = 1'b0;
    bus.i_alu_data_valid = 1'b0;
    #1;
    check("mr_rel_ready", 32'(bus.o_dec_ready), 32'd1);
    @(negedge clk);
    check("mr_no_wb", 32'(bus.o_wb_valid), 32'd0);

    // back-to-back: decode keeps offering while busy
    bus.i_wb_ready  = 1'b1;
    bus.i_use_imm   = 1'b0;
    bus.i_rd_addr   = 5'd5;
    bus.i_rs1_data  = 32'h0000_0011;
    bus.i_dec_valid = 1'b1;
    check("b2b_ready0", 32'(bus.o_dec_ready), 32'd1);
    @(negedge clk);
    check("b2b_c1_op1",   bus.o_operand_one,    32'h0000_0011);
    check("b2b_c1_ready", 32'(bus.o_dec_ready), 32'd0);
    bus.i_rs1_data       = 32'h0000_0022;
    bus.i_alu_data_valid = 1'b1;
    bus.i_alu_result     = 32'h0000_0100;
    @(negedge clk);
    bus.i_alu_data_valid = 1'b0;
    check("b2b_c2_op1",   bus.o_operand_one,    32'h0000_0011);
    check("b2b_c2_wbv",   32'(bus.o_wb_valid),  32'd1);
    check("b2b_c2_ready", 32'(bus.o_dec_ready), 32'd0);
    bus.i_rs1_data = 32'h0000_0033;
    @(negedge clk);
    check("b2b_c3_alu_rst", 32'(bus.o_alu_rst),   32'd1);
    check("b2b_c3_ready",   32'(bus.o_dec_ready), 32'd0);
    bus.i_rs1_data = 32'h0000_0044;
    @(negedge clk);
    check("b2b_c4_ready", 32'(bus.o_dec_ready), 32'd1);
    @(negedge clk);
    bus.i_dec_valid = 1'b0;
    check("b2b_c5_op1", bus.o_operand_one,   32'h0000_0044);
    check("b2b_c5_en",  32'(bus.o_en_alu),   32'd1);
    bus.i_alu_data_valid = 1'b1;
    bus.i_alu_result     = 32'h0000_0200;
    @(negedge clk);
    bus.i_alu_data_valid = 1'b0;
    check("b2b_c6_data", bus.o_wb_data,      32'h0000_0200);
    check("b2b_c6_op1",  bus.o_operand_one,  32'h0000_0044);
    @(negedge clk);
    check("b2b_c7_alu_rst", 32'(bus.o_alu_rst), 32'd1);
    @(negedge clk);
    check("b2b_c8_ready", 32'(bus.o_dec_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_alu_issue.md
# rv32_alu_issue

Issue sequencer sitting directly upstream of `rv32_alu_fsm`. It accepts a decoded ALU operation from decode through a valid/ready handshake and selects operand two (register or immediate). It holds the operands stable while it drives `i_en_alu`, waits for `o_data_valid` with a bounded timeout, and captures the result and carry. It then presents them to writeback through a valid/ready handshake, and restarts the ALU FSM between operations.

## Interface
- `TIMEOUT`, default 5: maximum cycles in ISSUE waiting for ALU `o_data_valid` before abort; legal range 1..255.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_dec_valid`  in  1  decode offers an operation.
- `o_dec_ready`  out  1  block accepts an operation.
- `i_rs1_data`  in  32  operand one.
- `i_rs2_data`  in  32  register operand two.
- `i_imm`  in  32  sign-extended immediate.
- `i_use_imm`  in  1  1: operand two = `i_imm`; 0: operand two = `i_rs2_data`.
- `i_alu_sel`  in  2  ALU operation select, passed through unchanged.
- `i_rd_addr`  in  5  destination register.
- `o_en_alu`  out  1  to ALU `i_en_alu`.
- `o_alu_rst`  out  1  to ALU `i_rst`.
- `o_operand_one`, `o_operand_two`  out  32  to ALU operands.
- `o_alu_sel`  out  2  to ALU `i_alu_sel`.
- `i_alu_data_valid`  in  1  from ALU `o_data_valid`.
- `i_alu_result`  in  32  from ALU `o_result`.
- `i_alu_carry`  in  1  from ALU `o_carry_out`.
- `o_wb_valid`  out  1  result offered to writeback.
- `i_wb_ready`  in  1  writeback accepts.
- `o_wb_data`  out  32  captured result.
- `o_wb_carry`  out  1  captured carry.
- `o_wb_rd_addr`  out  5  captured destination.
- `o_timeout_err`  out  1  sticky abort flag.
- `o_busy`  out  1  state != IDLE.

## Operation
- **States.**
  - IDLE: `o_dec_ready`=1.
  - On `i_dec_valid & o_dec_ready`:
    - register `i_rs1_data`, the muxed operand two, `i_alu_sel` and `i_rd_addr`;
    - clear the wait counter;
    - go to ISSUE.
  - ISSUE: `o_en_alu`=1; operand and select outputs stay constant for the whole operation.
    - Counter increments each ISSUE cycle in which `i_alu_data_valid`=0.
    - `i_alu_data_valid`=1: capture `i_alu_result`/`i_alu_carry` into the wb registers. If `rd`!=0 go to HOLD, else go to RECOVER (x0 writes are dropped; no `o_wb_valid`).
    - Counter reaches `TIMEOUT` with no valid: set `o_timeout_err`, go to RECOVER, no writeback.
    - If valid arrives in the same cycle the counter hits `TIMEOUT`, valid wins (no error).
  - HOLD: `o_wb_valid`=1, `o_en_alu`=1, and the wb outputs stay stable.
    - `i_wb_ready`=1: go to RECOVER.
    - Stall is unbounded; the timeout does not apply.
  - RECOVER: exactly one cycle with `o_alu_rst`=1 and `o_en_alu`=0, then IDLE.
- **`o_alu_rst`** = `i_rst` OR (state==RECOVER), combinational from registered state.
- **`o_timeout_err`** is sticky until `i_rst`; operation continues normally after an error.
- **Reset** (from any state, including mid-ISSUE or HOLD):
  - state forced to IDLE;
  - all data outputs 0;
  - `o_en_alu`, `o_wb_valid`, `o_timeout_err` and `o_busy` = 0;
  - `o_alu_rst`=1 while `i_rst`=1;
  - `o_dec_ready`=0 while `i_rst`=1, 1 from the first cycle after.
  - A pending writeback is discarded.
- `o_dec_ready` has no combinational path from `i_wb_ready` or `i_alu_data_valid`.

## Timing
- Cycle 0: handshake sampled.
- Cycle 1: `o_en_alu`=1 with operands valid.
- ALU valid sampled in cycle N ≥ 1 → `o_wb_valid`=1 in cycle N+1.
- Writeback accepted in cycle M → RECOVER in M+1 → IDLE with `o_dec_ready`=1 in M+2.
- Minimum accept-to-accept interval, with ALU valid in cycle 1 and `i_wb_ready` held high:
  - rd!=0: 4 cycles (accept, ISSUE, HOLD, RECOVER); next accept in cycle 4.
  - rd==0: 3 cycles (accept, ISSUE, RECOVER); next accept in cycle 3.
- Timeout: error set in the cycle after the `TIMEOUT`-th invalid ISSUE cycle; RECOVER follows immediately.
- Counter width is `$clog2(TIMEOUT+1)` and must not wrap before the comparison.

## Test plan
- Add, `i_rs1_data`=0x0000_0005, `i_rs2_data`=0x0000_0003, `i_use_imm`=0, rd=7, ALU valid 2 cycles after `o_en_alu`, `i_wb_ready`=1 → `o_wb_data`=0x8, `o_wb_carry`=0, `o_wb_rd_addr`=7; `o_alu_rst` pulse for one cycle; `o_dec_ready` back after RECOVER.
- `i_use_imm`=1, `i_imm`=0xFFFF_FFFF, `i_rs2_data`=0x1234, rs1=0x1 → `o_operand_two`=0xFFFF_FFFF; ALU returns 0x0 with carry=1 → `o_wb_carry`=1.
- ALU never asserts valid, `TIMEOUT`=5 → after 5 ISSUE cycles `o_timeout_err`=1 (sticky), no `o_wb_valid`, RECOVER pulse, next op completes normally with err still 1.
- `i_wb_ready` held 0 for 10 cycles in HOLD → `o_wb_valid` and the data stay stable and `o_en_alu` stays 1. `i_wb_ready`=1 → RECOVER next cycle.
- rd=0 → no `o_wb_valid`; ISSUE→RECOVER directly. Additionally, assert `i_rst` during ISSUE → next cycle: IDLE, all outputs 0, `o_alu_rst`=1 during reset, no writeback.
- Back-to-back: `i_dec_valid` held high with changing operands while busy → accepted only in IDLE; operands to the ALU never change during ISSUE or HOLD.
